// File: rtl/queue_if.sv
// Valid/ready handshake bundle for the queue: an input (enqueue) port and
// an output (dequeue) port. The master side is the environment (producer
// and consumer), the slave side is the queue itself.
interface queue_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    input  in_ready,
    output in_data,
    input  out_valid,
    output out_ready,
    input  out_data
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_data,
    output out_valid,
    input  out_ready,
    output out_data
  );
endinterface

// File: rtl/queue.sv
// In-order FIFO with valid/ready on both ports, occupancy output and sticky
// overflow/underflow debug flags. Head word is read combinationally from
// the registered read pointer, so a word written at edge N is visible right
// after edge N and there is no fall-through within a cycle.
module queue #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  queue_if.slave           bus,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             overflow_reg;
  logic             underflow_reg;
  logic             enq;
  logic             deq;

  // Status is decoded from registered occupancy only; in_ready deliberately
  // ignores out_ready so a full queue never accepts on the dequeue cycle.
  assign empty         = (count_reg == '0);
  assign full          = (count_reg == CNT_W'(DEPTH));
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : mem[rd_ptr_reg];
  assign count         = count_reg;
  assign overflow      = overflow_reg;
  assign underflow     = underflow_reg;

  assign enq = bus.in_valid && bus.in_ready;
  assign deq = bus.out_valid && bus.out_ready;

  // Occupancy: simultaneous enqueue and dequeue cancel out.
  always_comb begin
    count_next = count_reg;
    case ({enq, deq})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage array, not reset; a flushed enqueue is dropped.
  always_ff @(posedge clk) begin
    if (enq && !flush) begin
      mem[wr_ptr_reg] <= bus.in_data;
    end
  end

  // Pointers, occupancy and sticky flags; pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (flush) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (enq) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_next;
      if (bus.in_valid && full) begin
        overflow_reg <= 1'b1;
      end
      if (bus.out_ready && empty) begin
        underflow_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_queue.sv
// Directed bench for the queue: reset, ordering, full/overflow, wrap-around
// streaming, underflow/flush, full-with-dequeue and asynchronous reset.
module tb_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             flush;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  int tests_run;
  int tests_failed;

  queue_if #(.WIDTH(WIDTH)) bus ();

  queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus.slave),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] check %s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    chk(tag, bus.out_data, exp);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_data"}, bus.out_data, 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_unf"}, 32'(underflow), 32'd0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst           = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset held, then idle after release.
    tick();
    chk_idle("rst");
    rst = 1'b1;
    tick();
    tick();
    chk_idle("idle");

    // Ordering of three words.
    push(32'h11);
    chk("first_visible", bus.out_data, 32'h11);
    chk("first_valid", 32'(bus.out_valid), 32'd1);
    push(32'h22);
    push(32'h33);
    chk("cnt3", 32'(count), 32'd3);
    pop_check("ord0", 32'h11);
    pop_check("ord1", 32'h22);
    pop_check("ord2", 32'h33);
    chk("ord_empty", 32'(empty), 32'd1);
    chk("ord_zero", bus.out_data, 32'd0);

    // Fill, overflow attempt, drain.
    for (int i = 0; i < DEPTH; i++) push(32'(i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_ovf_pre", 32'(overflow), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEAD;
    tick();
    tick();
    bus.in_valid = 1'b0;
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    for (int i = 0; i < DEPTH; i++) pop_check($sformatf("drain%0d", i), 32'(i));
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_zero", bus.out_data, 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    do_flush();
    chk("flush_ovf_clr", 32'(overflow), 32'd0);

    // Streaming with both pointers wrapping.
    for (int i = 0; i < 4; i++) push(32'(100 + i));
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.in_data = 32'(104 + i);
      chk($sformatf("stream%0d", i), bus.out_data, 32'(100 + i));
      tick();
      chk($sformatf("stream_cnt%0d", i), 32'(count), 32'd4);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) pop_check($sformatf("stream_tail%0d", i), 32'(140 + i));
    chk("stream_empty", 32'(empty), 32'd1);

    // Underflow, then flush with a concurrent enqueue.
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("unf_set", 32'(underflow), 32'd1);
    chk("unf_count", 32'(count), 32'd0);
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h55;
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_unf", 32'(underflow), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_zero", bus.out_data, 32'd0);

    // Full queue with enqueue and dequeue together: only dequeue fires.
    for (int i = 0; i < DEPTH; i++) push(32'(200 + i));
    chk("fd_full", 32'(full), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hBEEF;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("fd_count", 32'(count), 32'd15);
    chk("fd_in_ready", 32'(bus.in_ready), 32'd1);
    chk("fd_head", bus.out_data, 32'd201);
    chk("fd_ovf", 32'(overflow), 32'd1);
    tick();
    chk("fd_count_hold", 32'(count), 32'd15);
    for (int i = 1; i < DEPTH; i++) pop_check($sformatf("fd_drain%0d", i), 32'(200 + i));
    chk("fd_no_beef", 32'(empty), 32'd1);

    // Asynchronous reset with 5 words in flight.
    do_flush();
    for (int i = 0; i < 5; i++) push(32'(300 + i));
    chk("ar_count5", 32'(count), 32'd5);
    #2;
    rst = 1'b0;
    #1;
    chk_idle("async_rst");
    tick();
    rst = 1'b1;
    push(32'h77);
    chk("ar_post_count", 32'(count), 32'd1);
    chk("ar_post_data", bus.out_data, 32'h77);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
